// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the round-robin memory arbiter: default memory
// geometry and the tag that travels alongside each accepted transaction.
package mem_ctrl_pkg;

   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_DEPTH      = 16;

   // Requester ids never exceed 3 bits since at most 8 requesters share the memory
   localparam int ID_WIDTH = 3;

   typedef struct packed {
      logic                valid;
      logic [ID_WIDTH-1:0] id;
      logic                wr;
      logic                err;
   } tag_t;

endpackage

// File: rtl/mem_rr_arbiter_rr_arbiter.sv
// Purely combinational round-robin picker: scans the request vector starting
// at the pointer and wrapping around, and reports the first set bit.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   winner
);

   logic found;
   int   idx;

   // Walk the requesters in priority order from ptr; the first active one wins
   always_comb begin
      gnt    = '0;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            winner   = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Shares one single-port memory between NUM_REQ requesters. One transaction
// is accepted per cycle; a two-stage tag pipeline routes each completion back
// to its requester, and out-of-range addresses complete with an error
// without ever reaching the memory.
module mem_rr_arbiter
   import mem_ctrl_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            req_wr,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic                          rsp_err,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic                          mem_en,
   output logic                          mem_wr,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   output logic [DATA_WIDTH-1:0]         mem_wdata,
   input  logic [DATA_WIDTH-1:0]         mem_rdata
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]    arb_gnt;
   logic [IDX_W-1:0]      winner;
   logic [IDX_W-1:0]      rr_ptr;
   logic [IDX_W-1:0]      ptr_next;
   logic                  accept;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [DATA_WIDTH-1:0] win_wdata;
   logic                  win_wr;
   logic                  win_err;
   tag_t                  tag_s1;
   tag_t                  tag_s2;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .req    (req),
      .ptr    (rr_ptr),
      .gnt    (arb_gnt),
      .winner (winner)
   );

   // Grants are suppressed while reset is held so nothing is accepted mid-reset
   assign gnt    = rst_n ? arb_gnt : '0;
   assign accept = |gnt;

   assign win_addr  = req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
   assign win_wdata = req_wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
   assign win_wr    = req_wr[winner];
   assign win_err   = (win_addr >= ADDR_WIDTH'(DEPTH));

   // Next pointer sits just past the winner, wrapping at the last requester
   always_comb begin
      ptr_next = winner + IDX_W'(1);
      if (int'(winner) == NUM_REQ - 1) begin
         ptr_next = '0;
      end
   end

   // Advance the round-robin pointer only when a handshake actually completes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (accept) begin
         rr_ptr <= ptr_next;
      end
   end

   // Issue stage: drive the memory for in-range winners and launch the stage-1 tag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_en    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         tag_s1    <= '0;
      end else begin
         mem_en <= 1'b0;
         tag_s1 <= '0;
         if (accept) begin
            tag_s1.valid <= 1'b1;
            tag_s1.id    <= ID_WIDTH'(winner);
            tag_s1.wr    <= win_wr;
            tag_s1.err   <= win_err;
            if (!win_err) begin
               mem_en    <= 1'b1;
               mem_wr    <= win_wr;
               mem_addr  <= win_addr;
               mem_wdata <= win_wdata;
            end
         end
      end
   end

   // Completion stage: the tag follows the memory access by one cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_s2 <= '0;
      end else begin
         tag_s2 <= tag_s1;
      end
   end

   // Responses are decoded straight from the stage-2 tag flops; read data is
   // claimed only by a tag that owns it, never by the memory's own valid flag
   always_comb begin
      rsp_valid = '0;
      rsp_err   = 1'b0;
      rsp_rdata = '0;
      if (tag_s2.valid) begin
         rsp_valid[tag_s2.id] = 1'b1;
         rsp_err              = tag_s2.err;
         if (!tag_s2.wr && !tag_s2.err) begin
            rsp_rdata = mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench for mem_rr_arbiter: a behavioural memory stands in for
// the real 16x32 part, and a transaction-level reference model predicts
// grants, memory pins and completions.
module tb_mem_rr_arbiter;

   localparam int N     = 2;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      req;
   logic [N-1:0]      req_wr;
   logic [N*AW-1:0]   req_addr;
   logic [N*DW-1:0]   req_wdata;
   logic [N-1:0]      gnt;
   logic [N-1:0]      rsp_valid;
   logic              rsp_err;
   logic [DW-1:0]     rsp_rdata;
   logic              mem_en;
   logic              mem_wr;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_wdata;
   logic [DW-1:0]     mem_rdata = '0;

   logic [DW-1:0]     mem_array [DEPTH] = '{default: '0};
   logic [DW-1:0]     ref_mem   [DEPTH] = '{default: '0};

   typedef struct {
      bit          v;
      int          id;
      bit          wr;
      bit          err;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } exp_t;

   exp_t s_a;
   exp_t s_b;
   int   ptr;
   int   vectors;
   int   miscompares;
   int   w;

   always #5 clk = ~clk;

   mem_rr_arbiter #(
      .NUM_REQ    (N),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .gnt       (gnt),
      .rsp_valid (rsp_valid),
      .rsp_err   (rsp_err),
      .rsp_rdata (rsp_rdata),
      .mem_en    (mem_en),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // Behavioural single-port memory: acts on the edge after en is presented
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_wr) begin
            mem_array[mem_addr[3:0]] <= mem_wdata;
         end else begin
            mem_rdata <= mem_array[mem_addr[3:0]];
         end
      end
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input int i, input bit on, input bit wr,
                                 input logic [31:0] addr, input logic [31:0] data);
      req[i]               = on;
      req_wr[i]            = wr;
      req_addr[i*AW +: AW] = addr;
      req_wdata[i*DW +: DW] = data;
   endtask

   task automatic clear_requests();
      for (int i = 0; i < N; i++) begin
         apply_stimulus(i, 1'b0, 1'b0, 32'h0, 32'h0);
      end
   endtask

   function automatic int model_winner(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) begin
            return (p + k) % N;
         end
      end
      return -1;
   endfunction

   function automatic exp_t empty_entry();
      exp_t e;
      e.v = 0; e.id = 0; e.wr = 0; e.err = 0;
      e.addr = '0; e.wdata = '0; e.rdata = '0;
      return e;
   endfunction

   // One clock: predict and check at the falling edge, then commit the model
   task automatic step_cycle(output int won);
      exp_t e;
      logic [31:0] a;
      @(negedge clk);
      won = model_winner(req, ptr);
      check_output("gnt", 32'(gnt), (won >= 0) ? (32'h1 << won) : 32'h0);
      check_output("mem_en", 32'(mem_en), 32'(s_a.v && !s_a.err));
      if (s_a.v && !s_a.err) begin
         check_output("mem_wr", 32'(mem_wr), 32'(s_a.wr));
         check_output("mem_addr", mem_addr, s_a.addr);
         if (s_a.wr) begin
            check_output("mem_wdata", mem_wdata, s_a.wdata);
         end
      end
      check_output("rsp_valid", 32'(rsp_valid), s_b.v ? (32'h1 << s_b.id) : 32'h0);
      if (s_b.v) begin
         check_output("rsp_err", 32'(rsp_err), 32'(s_b.err));
      end
      check_output("rsp_rdata", rsp_rdata, s_b.v ? s_b.rdata : 32'h0);
      s_b = s_a;
      e = empty_entry();
      if (won >= 0) begin
         a       = req_addr[won*AW +: AW];
         e.v     = 1;
         e.id    = won;
         e.wr    = req_wr[won];
         e.err   = (a >= DEPTH);
         e.addr  = a;
         e.wdata = req_wdata[won*DW +: DW];
         if (!e.wr && !e.err) begin
            e.rdata = ref_mem[a[3:0]];
         end
         if (e.wr && !e.err) begin
            ref_mem[a[3:0]] = e.wdata;
         end
         ptr = (won + 1) % N;
      end
      s_a = e;
      @(posedge clk);
      #1;
   endtask

   // Assert reset now, check the quiet outputs, release on a falling edge
   task automatic do_reset();
      rst_n = 1'b0;
      ptr   = 0;
      s_a   = empty_entry();
      s_b   = empty_entry();
      repeat (2) begin
         @(negedge clk);
         check_output("rst_gnt", 32'(gnt), 32'h0);
         check_output("rst_mem_en", 32'(mem_en), 32'h0);
         check_output("rst_rsp_valid", 32'(rsp_valid), 32'h0);
         check_output("rst_rsp_err", 32'(rsp_err), 32'h0);
      end
      clear_requests();
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      ptr         = 0;
      s_a         = empty_entry();
      s_b         = empty_entry();
      rst_n       = 1'b0;
      clear_requests();

      // Power-on reset with a request held: no grant may appear
      apply_stimulus(0, 1'b1, 1'b0, 32'd3, 32'h0);
      do_reset();

      // Reset mid-flight: read accepted, reset lands after the memory edge
      $display("[TB] reset mid-flight");
      apply_stimulus(0, 1'b1, 1'b0, 32'd3, 32'h0);
      step_cycle(w);
      clear_requests();
      step_cycle(w);
      do_reset();

      // Fairness: both requesters held for six cycles, pointer starts at 0
      $display("[TB] fairness");
      apply_stimulus(0, 1'b1, 1'b0, 32'd1, 32'h0);
      apply_stimulus(1, 1'b1, 1'b0, 32'd2, 32'h0);
      repeat (6) step_cycle(w);
      clear_requests();
      repeat (2) step_cycle(w);

      // Single write then read from requester 0
      $display("[TB] write then read");
      apply_stimulus(0, 1'b1, 1'b1, 32'd5, 32'hDEADBEEF);
      step_cycle(w);
      apply_stimulus(0, 1'b1, 1'b0, 32'd5, 32'h0);
      step_cycle(w);
      clear_requests();
      repeat (3) step_cycle(w);

      // Out-of-range read and write, then confirm address 15 is untouched
      $display("[TB] out of range");
      apply_stimulus(1, 1'b1, 1'b0, 32'd16, 32'h0);
      step_cycle(w);
      apply_stimulus(1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678);
      step_cycle(w);
      clear_requests();
      step_cycle(w);
      apply_stimulus(0, 1'b1, 1'b0, 32'd15, 32'h0);
      step_cycle(w);
      clear_requests();
      repeat (3) step_cycle(w);

      // Pipelined mix: write from r0 immediately followed by read from r1
      $display("[TB] pipelined mix");
      apply_stimulus(0, 1'b1, 1'b1, 32'd7, 32'h11);
      step_cycle(w);
      apply_stimulus(0, 1'b0, 1'b0, 32'd0, 32'h0);
      apply_stimulus(1, 1'b1, 1'b0, 32'd7, 32'h0);
      step_cycle(w);
      clear_requests();

      // Idle hold: no requests for four cycles after the read
      repeat (4) step_cycle(w);

      // Randomized traffic against the reference model
      $display("[TB] random traffic");
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req[i] && $urandom_range(0, 3) != 0) begin
               int unsigned r;
               logic [31:0] a;
               r = $urandom_range(0, 9);
               if (r == 0) begin
                  a = $urandom;
               end else if (r < 3) begin
                  a = 32'(16 + $urandom_range(0, 3));
               end else begin
                  a = 32'($urandom_range(0, 15));
               end
               apply_stimulus(i, 1'b1, 1'($urandom_range(0, 1)), a, $urandom);
            end
         end
         step_cycle(w);
         if (w >= 0) begin
            req[w] = 1'b0;
         end
      end
      clear_requests();
      repeat (3) step_cycle(w);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Shares the single-port 16x32 memory between NUM_REQ independent requesters using round-robin arbitration.
- Accepts one read or write per cycle, fully pipelined.
- Drives the memory's en/wr/addr/data_in pins and routes each completion back to the requester that issued it.
- Rejects out-of-range addresses without touching the memory.

Parameters:
- NUM_REQ, 2: number of requesters; legal range 2..8.
- ADDR_WIDTH, 32: address width, matches the memory.
- DATA_WIDTH, 32: data width, matches the memory.
- DEPTH, 16: number of memory words; an address >= DEPTH is out of range.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request; held until granted.
- req_wr  in  NUM_REQ  per-requester 1=write, 0=read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  per-requester address, requester i in slice i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  per-requester write data.
- gnt  out  NUM_REQ  one-hot grant, combinational; handshake completes on a rising edge with req[i]&gnt[i].
- rsp_valid  out  NUM_REQ  one-hot completion pulse, registered.
- rsp_err  out  1  qualifies rsp_valid: 1 = address out of range.
- rsp_rdata  out  DATA_WIDTH  read data; meaningful when rsp_valid is set for a read without error.
- mem_en  out  1  to memory en, registered.
- mem_wr  out  1  to memory wr, registered.
- mem_addr  out  ADDR_WIDTH  to memory addr, registered.
- mem_wdata  out  DATA_WIDTH  to memory data_in, registered.
- mem_rdata  in  DATA_WIDTH  from memory data_out.

Behaviour:
- Reset (async assert, sync release):
  - mem_en, mem_wr, mem_addr, mem_wdata = 0; rsp_valid = 0; rsp_err = 0.
  - rr_ptr = 0; both pipeline tag stages invalid.
  - Transactions in flight when reset asserts are dropped; no rsp_valid is produced for them.
- Arbitration:
  - Each cycle, search req starting at index rr_ptr upward with wrap-around; the first set bit wins.
  - gnt is one-hot or zero; gnt = 0 whenever req = 0.
  - On an accepted grant to index w: rr_ptr <= (w+1) mod NUM_REQ. Otherwise rr_ptr holds.
  - No grants are issued while rst_n = 0.
- Issue stage (edge E0, the handshake edge):
  - In range (addr < DEPTH): mem_en <= 1; mem_wr, mem_addr, mem_wdata are loaded from the winner.
  - Out of range: mem_en <= 0.
  - Stage-1 tag <= {valid=1, id=w, wr, err}.
  - With no grant: mem_en <= 0 and the tag is invalid; mem_addr and mem_wdata hold.
- Memory acts at E1. Read data is on mem_rdata after E1.
- Completion stage:
  - At E1, stage-1 tag moves to stage-2 tag.
  - rsp_valid[id] is asserted for the cycle between E1 and E2, i.e. two cycles of latency from the grant edge.
  - rsp_err = tag.err. rsp_rdata = mem_rdata when the tag is a read with no error, else 0.
  - Every accepted transaction (read, write, or error) produces exactly one rsp_valid pulse.
  - Completions appear in grant order.
- Memory valid_out is unused: it holds its value while en = 0, so ownership of read data comes only from the tag.
- Throughput: one grant per cycle with no bubbles. Back-to-back reads return on consecutive cycles.
- Ordering: write-then-read to the same address, granted on consecutive cycles, returns the new data.
- No combinational path from mem_rdata to gnt.

Decomposition:
- Package mem_ctrl_pkg:
  - ADDR_WIDTH, DATA_WIDTH, DEPTH defaults.
  - Typedef tag_t {logic valid; logic [$clog2(NUM_REQ)-1:0] id; logic wr; logic err}, with id sized to 3 bits max.
- Sub-module rr_arbiter: NUM_REQ parameter; inputs req, ptr; outputs gnt (one-hot) and winner index. Purely combinational.
- The pointer register, issue stage and tag pipeline stay in the top module.

Test Plan:
- Reset mid-flight: req[0] reads addr 3 at E0, rst_n pulsed low before E2 -> no rsp_valid; after release, rr_ptr = 0 and mem_en = 0.
- Single write then read: req[0] writes 0xDEADBEEF to addr 5, then req[0] reads addr 5 -> write rsp_valid[0] at E0+2; read rsp_valid[0] with rsp_rdata = 0xDEADBEEF at E0+2 of the read; rsp_err = 0.
- Fairness: req = 2'b11 held for 6 cycles with addresses 1 and 2 -> gnt sequence 01,10,01,10,01,10; rsp_valid follows the same sequence delayed by 2 cycles.
- Out of range: req[1] reads addr 16, then writes addr 0xFFFF_FFFF -> mem_en stays 0; rsp_valid[1] with rsp_err = 1, rsp_rdata = 0; memory contents unchanged.
- Pipelined mix: back-to-back grants W(r0, addr 7, 0x11) then R(r1, addr 7) -> r1 receives 0x11 one cycle after r0's write ack.
- Idle hold: req = 0 for 4 cycles after a read -> gnt = 0, mem_en = 0, rsp_valid = 0 even though the memory's valid_out stays 1.
